free_list: RTL

- Physical-register free list that sits between the reorder buffer commit port and rename/dispatch.
- Supplies up to 4 free physical destination registers (prd) per cycle to the dispatch group.
- Reclaims up to 4 prd per cycle from the ROB commit bundle (com_prd4x / com_en).
- Implemented as a circular queue of register indices with a non-power-of-two depth and 4-wide compacting push/pop.

---
 rtl/free_list.sv | 116 +++++++++++
 1 files changed

// File: rtl/free_list.sv
// Physical-register free list: circular queue of prd indices with 4-wide
// compacting pop (rename/dispatch) and 4-wide compacting push (ROB commit).
module free_list #(
    parameter int WIDTH_REG = 7,
    parameter int NARCH     = 32,
    parameter int SIZE      = 2**WIDTH_REG - NARCH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic [4*WIDTH_REG-1:0] o_prd4x,
    output logic                   o_ready,
    output logic [WIDTH_REG-1:0]   o_count,
    output logic                   o_overflow,
    input  logic                   i_alloc_en,
    input  logic [3:0]             i_alloc_mask,
    input  logic                   i_com_en,
    input  logic [4*WIDTH_REG-1:0] i_com_prd4x,
    input  logic [3:0]             i_com_mask
);

    localparam int SW = WIDTH_REG + 1;
    localparam logic [SW-1:0] SIZE_W = SW'(SIZE);

    logic [WIDTH_REG-1:0] mem_reg [SIZE];
    logic [WIDTH_REG-1:0] head_reg, head_next;
    logic [WIDTH_REG-1:0] tail_reg, tail_next;
    logic [WIDTH_REG-1:0] count_reg, count_next;
    logic                 overflow_reg, overflow_next;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Depth is not a power of two, so wrap by a single conditional subtract.
    function automatic logic [WIDTH_REG-1:0] ptr_add(input logic [WIDTH_REG-1:0] ptr,
                                                     input logic [2:0] n);
        logic [SW-1:0] sum;
        sum = {1'b0, ptr} + SW'(n);
        if (sum >= SIZE_W)
            sum = sum - SIZE_W;
        return sum[WIDTH_REG-1:0];
    endfunction

    logic [3:0]           push_cand;
    logic [2:0]           pop_rank  [4];
    logic [2:0]           push_rank [4];
    logic [WIDTH_REG-1:0] rd_addr   [4];
    logic [WIDTH_REG-1:0] wr_addr   [4];
    logic [WIDTH_REG-1:0] com_prd   [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            localparam logic [3:0] LOWER = 4'((1 << gi) - 1);
            assign com_prd[gi]   = i_com_prd4x[gi*WIDTH_REG +: WIDTH_REG];
            // p0 is the hardwired zero register and never returns to the pool.
            assign push_cand[gi] = i_com_en && i_com_mask[gi] && (com_prd[gi] != '0);
            assign pop_rank[gi]  = popcount4(i_alloc_mask & LOWER);
            assign push_rank[gi] = popcount4(push_cand & LOWER);
            assign rd_addr[gi]   = ptr_add(head_reg, pop_rank[gi]);
            assign wr_addr[gi]   = ptr_add(tail_reg, push_rank[gi]);
            assign o_prd4x[gi*WIDTH_REG +: WIDTH_REG] = mem_reg[rd_addr[gi]];
        end
    endgenerate

    logic [2:0]    npop, npush, pop_amt;
    logic          pop_fire, push_fire, push_ovf;
    logic [SW-1:0] count_after;

    always_comb begin
        npop        = popcount4(i_alloc_mask);
        npush       = popcount4(push_cand);
        pop_fire    = i_alloc_en && (WIDTH_REG'(npop) <= count_reg);
        pop_amt     = pop_fire ? npop : 3'd0;
        count_after = {1'b0, count_reg} - SW'(pop_amt) + SW'(npush);
        // An overfull push is dropped as a whole; the pop is unaffected.
        push_ovf    = count_after > SIZE_W;
        push_fire   = !push_ovf;

        head_next     = pop_fire ? ptr_add(head_reg, npop) : head_reg;
        tail_next     = push_fire ? ptr_add(tail_reg, npush) : tail_reg;
        count_next    = push_fire ? count_after[WIDTH_REG-1:0]
                                  : count_reg - WIDTH_REG'(pop_amt);
        overflow_next = overflow_reg | push_ovf;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= WIDTH_REG'(SIZE);
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SIZE; i++)
                mem_reg[i] <= WIDTH_REG'(NARCH + i);
        end else if (push_fire) begin
            for (int k = 0; k < 4; k++)
                if (push_cand[k])
                    mem_reg[wr_addr[k]] <= com_prd[k];
        end
    end

    assign o_count    = count_reg;
    assign o_ready    = count_reg >= WIDTH_REG'(4);
    assign o_overflow = overflow_reg;

endmodule
